// File: rtl/axis_head_cut_vere.sv
// Strips a per-packet number of leading bytes from an AXI-stream and realigns the rest to lane 0.
// Define AXIS_HEAD_CUT_VERE_STAT_EN to add the pkt_cnt / drop_cnt statistics outputs.
module axis_head_cut_vere #(
   parameter int DSIZE       = 32,
   parameter int BYTE_BITS   = 8,
   parameter int LEN_BITS    = 16,
   parameter int LFIFO_DEPTH = 4
) (
   input  logic                           clock,
   input  logic                           rst_n,
   input  logic [LEN_BITS-1:0]            len_tdata,
   input  logic                           len_tvalid,
   output logic                           len_tready,
   input  logic [DSIZE-1:0]               s_axis_tdata,
   input  logic [DSIZE/BYTE_BITS-1:0]     s_axis_tkeep,
   input  logic                           s_axis_tvalid,
   output logic                           s_axis_tready,
   input  logic                           s_axis_tlast,
   output logic [DSIZE-1:0]               m_axis_tdata,
   output logic [DSIZE/BYTE_BITS-1:0]     m_axis_tkeep,
   output logic                           m_axis_tvalid,
   input  logic                           m_axis_tready,
   output logic                           m_axis_tlast
`ifdef AXIS_HEAD_CUT_VERE_STAT_EN
   ,
   output logic [31:0]                    pkt_cnt,
   output logic [31:0]                    drop_cnt
`endif
);

   localparam int NB = DSIZE / BYTE_BITS;
   localparam int SW = (NB > 1) ? $clog2(NB) : 1;
   localparam int CW = $clog2(NB + 1);
   localparam int AW = (LFIFO_DEPTH > 1) ? $clog2(LFIFO_DEPTH) : 1;

   typedef enum logic [2:0] {IDLE = 3'd0, SKIP = 3'd1, FIRST = 3'd2, MERGE = 3'd3, FLUSH = 3'd4} state_t;

   function automatic logic [CW-1:0] keep_count(input logic [NB-1:0] k);
      logic [CW-1:0] c;
      c = '0;
      for (int i = 0; i < NB; i++) c = c + CW'(k[i]);
      return c;
   endfunction

   function automatic logic [NB-1:0] keep_mask(input int n);
      logic [NB-1:0] m;
      for (int i = 0; i < NB; i++) m[i] = (i < n);
      return m;
   endfunction

   logic [LEN_BITS-1:0] len_mem [LFIFO_DEPTH];
   logic [AW-1:0]       wr_ptr_reg, rd_ptr_reg;
   logic [AW:0]         count_reg;
   logic                len_push, len_pop;
   logic [LEN_BITS-1:0] head_len, head_skip;
   logic [SW-1:0]       head_shift;

   state_t              state_reg, state_next;
   logic [LEN_BITS-1:0] skip_reg, skip_next;
   logic [SW-1:0]       shift_reg, shift_next;
   logic [DSIZE-1:0]    hold_reg, hold_next;
   logic [CW-1:0]       flush_reg, flush_next;

   logic                out_free, s_hs;
   int                  shift_i, v_i;
   logic [DSIZE-1:0]    in_shr, in_shl, merged;
   logic                emit, emit_last;
   logic [DSIZE-1:0]    emit_data, emit_masked;
   logic [NB-1:0]       emit_keep;

   assign len_tready = (count_reg != (AW+1)'(LFIFO_DEPTH));
   assign len_push   = len_tvalid && len_tready;

   always_ff @(posedge clock) begin
      if (len_push) len_mem[wr_ptr_reg] <= len_tdata;
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (len_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (len_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
         count_reg <= count_reg + (AW+1)'(len_push) - (AW+1)'(len_pop);
      end
   end

   assign head_len   = len_mem[rd_ptr_reg];
   assign head_skip  = head_len / LEN_BITS'(NB);
   assign head_shift = SW'(head_len % LEN_BITS'(NB));

   // Inputs are only taken once the packet's cut parameters are latched, giving one idle cycle per packet.
   assign out_free      = !m_axis_tvalid || m_axis_tready;
   assign s_axis_tready = out_free && (state_reg == SKIP || state_reg == FIRST || state_reg == MERGE);
   assign s_hs          = s_axis_tvalid && s_axis_tready;

   assign shift_i = int'(shift_reg);
   assign v_i     = int'(keep_count(s_axis_tkeep));
   assign in_shr  = s_axis_tdata >> (shift_i * BYTE_BITS);
   assign in_shl  = s_axis_tdata << ((NB - shift_i) * BYTE_BITS);
   assign merged  = hold_reg | in_shl;

   always_comb begin
      state_next = state_reg;
      skip_next  = skip_reg;
      shift_next = shift_reg;
      hold_next  = hold_reg;
      flush_next = flush_reg;
      len_pop    = 1'b0;
      emit       = 1'b0;
      emit_data  = '0;
      emit_keep  = '0;
      emit_last  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (count_reg != '0) begin
               skip_next  = head_skip;
               shift_next = head_shift;
               state_next = (head_skip != '0) ? SKIP : FIRST;
            end
         end
         SKIP: begin
            if (s_hs) begin
               if (s_axis_tlast) begin
                  len_pop    = 1'b1;
                  state_next = IDLE;
               end else begin
                  skip_next = skip_reg - LEN_BITS'(1);
                  if (skip_reg == LEN_BITS'(1)) state_next = FIRST;
               end
            end
         end
         FIRST: begin
            if (s_hs) begin
               if (shift_reg == '0) begin
                  emit      = 1'b1;
                  emit_data = s_axis_tdata;
                  emit_keep = s_axis_tkeep;
                  emit_last = s_axis_tlast;
                  if (s_axis_tlast) begin
                     len_pop    = 1'b1;
                     state_next = IDLE;
                  end
               end else if (!s_axis_tlast) begin
                  hold_next  = in_shr;
                  state_next = MERGE;
               end else begin
                  len_pop    = 1'b1;
                  state_next = IDLE;
                  if (v_i > shift_i) begin
                     emit      = 1'b1;
                     emit_data = in_shr;
                     emit_keep = keep_mask(v_i - shift_i);
                     emit_last = 1'b1;
                  end
               end
            end
         end
         MERGE: begin
            if (s_hs) begin
               emit      = 1'b1;
               emit_data = merged;
               emit_keep = '1;
               hold_next = in_shr;
               if (s_axis_tlast) begin
                  len_pop = 1'b1;
                  if (v_i <= shift_i) begin
                     emit_keep  = keep_mask(NB - shift_i + v_i);
                     emit_last  = 1'b1;
                     state_next = IDLE;
                  end else begin
                     flush_next = CW'(v_i - shift_i);
                     state_next = FLUSH;
                  end
               end
            end
         end
         FLUSH: begin
            if (out_free) begin
               emit       = 1'b1;
               emit_data  = hold_reg;
               emit_keep  = keep_mask(int'(flush_reg));
               emit_last  = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Lanes outside tkeep are forced to zero so stale bytes never leak downstream.
   for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      assign emit_masked[gi*BYTE_BITS +: BYTE_BITS] =
         emit_keep[gi] ? emit_data[gi*BYTE_BITS +: BYTE_BITS] : '0;
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         skip_reg      <= '0;
         shift_reg     <= '0;
         hold_reg      <= '0;
         flush_reg     <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tkeep  <= '0;
         m_axis_tlast  <= 1'b0;
      end else begin
         state_reg <= state_next;
         skip_reg  <= skip_next;
         shift_reg <= shift_next;
         hold_reg  <= hold_next;
         flush_reg <= flush_next;
         if (out_free) begin
            m_axis_tvalid <= emit;
            if (emit) begin
               m_axis_tdata <= emit_masked;
               m_axis_tkeep <= emit_keep;
               m_axis_tlast <= emit_last;
            end
         end
      end
   end

`ifdef AXIS_HEAD_CUT_VERE_STAT_EN
   logic drop;
   assign drop = s_hs && s_axis_tlast &&
                 ((state_reg == SKIP) ||
                  (state_reg == FIRST && shift_reg != '0 && v_i <= shift_i));

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         pkt_cnt  <= '0;
         drop_cnt <= '0;
      end else begin
         if (m_axis_tvalid && m_axis_tready && m_axis_tlast) pkt_cnt <= pkt_cnt + 32'd1;
         if (drop) drop_cnt <= drop_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_axis_head_cut_vere.sv
// Randomised bench for axis_head_cut_vere against a byte-queue reference model.
module tb_axis_head_cut_vere;
   localparam int DSIZE = 32, BYTE_BITS = 8, LEN_BITS = 16, LFIFO_DEPTH = 4;
   localparam int NB = DSIZE / BYTE_BITS;
   localparam int TMO = 3000;

   logic                clock, rst_n;
   logic [LEN_BITS-1:0] len_tdata;
   logic                len_tvalid, len_tready;
   logic [DSIZE-1:0]    s_axis_tdata, m_axis_tdata;
   logic [NB-1:0]       s_axis_tkeep, m_axis_tkeep;
   logic                s_axis_tvalid, s_axis_tready, s_axis_tlast;
   logic                m_axis_tvalid, m_axis_tready, m_axis_tlast;
`ifdef AXIS_HEAD_CUT_VERE_STAT_EN
   logic [31:0]         pkt_cnt, drop_cnt;
`endif

   axis_head_cut_vere #(.DSIZE(DSIZE), .BYTE_BITS(BYTE_BITS), .LEN_BITS(LEN_BITS),
                        .LFIFO_DEPTH(LFIFO_DEPTH)) dut (
      .clock(clock), .rst_n(rst_n),
      .len_tdata(len_tdata), .len_tvalid(len_tvalid), .len_tready(len_tready),
      .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast)
`ifdef AXIS_HEAD_CUT_VERE_STAT_EN
      , .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
`endif
   );

   int checks = 0, errors = 0;
   int cyc = 0;
   int first_in_cyc, first_out_cyc;
   bit bp_en = 0;

   // packets under test and the model's expected output
   logic [7:0]       pbytes[$];
   int               pstart[$], plens[$], pL[$];
   logic [DSIZE-1:0] exp_data[$], got_data[$];
   logic [NB-1:0]    exp_keep[$], got_keep[$];
   bit               exp_last[$], got_last[$];

   initial begin
      clock = 0;
      forever #5 clock = ~clock;
   end

   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      m_axis_tready = 1'b1;
      forever begin
         @(posedge clock);
         #1 m_axis_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   initial begin
      forever begin
         @(negedge clock);
         if (rst_n) begin
            if (m_axis_tvalid && m_axis_tready) begin
               got_data.push_back(m_axis_tdata);
               got_keep.push_back(m_axis_tkeep);
               got_last.push_back(m_axis_tlast);
            end
            if (s_axis_tvalid && s_axis_tready && first_in_cyc < 0) first_in_cyc = cyc;
            if (m_axis_tvalid && first_out_cyc < 0) first_out_cyc = cyc;
         end
      end
   end

   task automatic clear_all();
      pbytes.delete(); pstart.delete(); plens.delete(); pL.delete();
      exp_data.delete(); exp_keep.delete(); exp_last.delete();
      got_data.delete(); got_keep.delete(); got_last.delete();
      first_in_cyc = -1;
      first_out_cyc = -1;
   endtask

   // Reference: the surviving bytes pbytes[L..n-1], chunked NB at a time from lane 0.
   task automatic add_pkt(input int n, input int L, input bit rnd);
      int base;
      logic [DSIZE-1:0] d;
      logic [NB-1:0] k;
      base = pbytes.size();
      pstart.push_back(base);
      plens.push_back(n);
      pL.push_back(L);
      for (int j = 0; j < n; j++) pbytes.push_back(rnd ? 8'($urandom) : 8'(j));
      for (int s = L; s < n; s += NB) begin
         d = '0;
         k = '0;
         for (int j = 0; j < NB; j++)
            if (s + j < n) begin
               d[j*8 +: 8] = pbytes[base + s + j];
               k[j] = 1'b1;
            end
         exp_data.push_back(d);
         exp_keep.push_back(k);
         exp_last.push_back(s + NB >= n);
      end
   endtask

   task automatic push_len(input int L);
      int t = 0;
      len_tdata = LEN_BITS'(L);
      len_tvalid = 1'b1;
      @(negedge clock);
      while (!len_tready && t < TMO) begin @(negedge clock); t++; end
      if (t >= TMO) begin
         checks++; errors++;
         $display("FAIL len_push_timeout got len_tready=0 expected 1");
      end
      @(posedge clock);
      #1 len_tvalid = 1'b0;
   endtask

   task automatic send_pkt(input int i, input bit gaps, input int max_beats);
      int base, n, t;
      base = pstart[i];
      n = plens[i];
      for (int b = 0; b * NB < n && b < max_beats; b++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            s_axis_tvalid = 1'b0;
            @(posedge clock);
            #1;
         end
         s_axis_tdata = '0;
         s_axis_tkeep = '0;
         for (int j = 0; j < NB; j++)
            if (b * NB + j < n) begin
               s_axis_tdata[j*8 +: 8] = pbytes[base + b * NB + j];
               s_axis_tkeep[j] = 1'b1;
            end
         s_axis_tlast = ((b + 1) * NB >= n);
         s_axis_tvalid = 1'b1;
         t = 0;
         @(negedge clock);
         while (!s_axis_tready && t < TMO) begin @(negedge clock); t++; end
         if (t >= TMO) begin
            checks++; errors++;
            $display("FAIL s_accept_timeout got s_axis_tready=0 expected 1 (pkt %0d beat %0d)", i, b);
         end
         @(posedge clock);
         #1;
      end
      s_axis_tvalid = 1'b0;
      s_axis_tdata = '0;
      s_axis_tkeep = '0;
      s_axis_tlast = 1'b0;
   endtask

   task automatic run_packets(input int first_len, input bit bp);
      int t = 0;
      bp_en = bp;
      fork
         begin
            for (int i = first_len; i < pL.size(); i++) push_len(pL[i]);
         end
         begin
            for (int i = 0; i < plens.size(); i++) send_pkt(i, bp, 1000);
         end
      join
      while (got_data.size() < exp_data.size() && t < TMO) begin @(posedge clock); t++; end
      if (t >= TMO) begin
         checks++; errors++;
         $display("FAIL drain_timeout got %0d beats expected %0d", got_data.size(), exp_data.size());
      end
      repeat (10) @(posedge clock);
      #1 bp_en = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      len_tvalid = 0; len_tdata = '0;
      s_axis_tvalid = 0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 0;
      clear_all();
      repeat (3) @(posedge clock);
      #1;
      checks++;
      if ({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast} !== '0) begin
         errors++;
         $display("FAIL reset_out got v=%0b d=%h k=%h l=%0b expected all 0",
                  m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast);
      end
      checks++;
      if ({len_tready, s_axis_tready} !== 2'b10) begin
         errors++;
         $display("FAIL reset_ready got len_tready=%0b s_tready=%0b expected 1 0", len_tready, s_axis_tready);
      end
      rst_n = 1'b1;
      @(posedge clock);
      #1;
   endtask

   task automatic test_passthrough();
      clear_all();
      add_pkt(12, 0, 0);
      run_packets(0, 0);
      checks++;
      if (got_data.size() !== exp_data.size()) begin
         errors++; $display("FAIL pass_beats got %0d expected %0d", got_data.size(), exp_data.size());
      end
      for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
         checks++;
         if ({got_data[i], got_keep[i], got_last[i]} !== {exp_data[i], exp_keep[i], exp_last[i]}) begin
            errors++;
            $display("FAIL pass_beat%0d got d=%h k=%h l=%0b expected d=%h k=%h l=%0b", i,
                     got_data[i], got_keep[i], got_last[i], exp_data[i], exp_keep[i], exp_last[i]);
         end
      end
      checks++;
      if (first_out_cyc - first_in_cyc !== 1) begin
         errors++; $display("FAIL pass_latency got %0d expected 1", first_out_cyc - first_in_cyc);
      end
   endtask

   task automatic test_cut(input string nm, input int n, input int L1, input int L2);
      clear_all();
      add_pkt(n, L1, 0);
      if (L2 >= 0) add_pkt(n, L2, 0);
      run_packets(0, 0);
      checks++;
      if (got_data.size() !== exp_data.size()) begin
         errors++; $display("FAIL %s_beats got %0d expected %0d", nm, got_data.size(), exp_data.size());
      end
      for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
         checks++;
         if ({got_data[i], got_keep[i], got_last[i]} !== {exp_data[i], exp_keep[i], exp_last[i]}) begin
            errors++;
            $display("FAIL %s_beat%0d got d=%h k=%h l=%0b expected d=%h k=%h l=%0b", nm, i,
                     got_data[i], got_keep[i], got_last[i], exp_data[i], exp_keep[i], exp_last[i]);
         end
      end
   endtask

   task automatic test_drop();
`ifdef AXIS_HEAD_CUT_VERE_STAT_EN
      logic [31:0] d0 = drop_cnt;
`endif
      clear_all();
      add_pkt(12, 12, 0);
      add_pkt(12, 20, 0);
      add_pkt(12, 0, 0);
      run_packets(0, 0);
      checks++;
      if (got_data.size() !== 3) begin
         errors++; $display("FAIL drop_beats got %0d expected 3", got_data.size());
      end
      for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
         checks++;
         if ({got_data[i], got_keep[i], got_last[i]} !== {exp_data[i], exp_keep[i], exp_last[i]}) begin
            errors++;
            $display("FAIL drop_beat%0d got d=%h k=%h l=%0b expected d=%h k=%h l=%0b", i,
                     got_data[i], got_keep[i], got_last[i], exp_data[i], exp_keep[i], exp_last[i]);
         end
      end
      // all three lengths consumed: queue empty, so the block parks with input closed
      @(negedge clock);
      checks++;
      if ({s_axis_tready, len_tready} !== 2'b01) begin
         errors++;
         $display("FAIL drop_queue_empty got s_tready=%0b len_tready=%0b expected 0 1", s_axis_tready, len_tready);
      end
`ifdef AXIS_HEAD_CUT_VERE_STAT_EN
      checks++;
      if (drop_cnt - d0 !== 32'd2) begin
         errors++; $display("FAIL drop_cnt got %0d expected 2", drop_cnt - d0);
      end
`endif
      @(posedge clock);
      #1;
   endtask

   task automatic test_queue_full_backpressure();
      clear_all();
      for (int i = 0; i < 5; i++) add_pkt($urandom_range(1, 16), $urandom_range(0, 14), 1);
      for (int i = 0; i < 4; i++) begin
         push_len(pL[i]);
         @(negedge clock);
         checks++;
         if (len_tready !== (i < 3)) begin
            errors++; $display("FAIL qfull_len_tready%0d got %0b expected %0b", i + 1, len_tready, (i < 3));
         end
         @(posedge clock);
         #1;
      end
      run_packets(4, 1);
      checks++;
      if (got_data.size() !== exp_data.size()) begin
         errors++; $display("FAIL qfull_beats got %0d expected %0d", got_data.size(), exp_data.size());
      end
      for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
         checks++;
         if ({got_data[i], got_keep[i], got_last[i]} !== {exp_data[i], exp_keep[i], exp_last[i]}) begin
            errors++;
            $display("FAIL qfull_beat%0d got d=%h k=%h l=%0b expected d=%h k=%h l=%0b", i,
                     got_data[i], got_keep[i], got_last[i], exp_data[i], exp_keep[i], exp_last[i]);
         end
      end
   endtask

   task automatic test_random_back_to_back();
      clear_all();
      for (int i = 0; i < 16; i++) add_pkt($urandom_range(1, 20), $urandom_range(0, 24), 1);
      run_packets(0, 1);
      checks++;
      if (got_data.size() !== exp_data.size()) begin
         errors++; $display("FAIL rand_beats got %0d expected %0d", got_data.size(), exp_data.size());
      end
      for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
         checks++;
         if ({got_data[i], got_keep[i], got_last[i]} !== {exp_data[i], exp_keep[i], exp_last[i]}) begin
            errors++;
            $display("FAIL rand_beat%0d got d=%h k=%h l=%0b expected d=%h k=%h l=%0b", i,
                     got_data[i], got_keep[i], got_last[i], exp_data[i], exp_keep[i], exp_last[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      clear_all();
      add_pkt(12, 0, 1);
      fork
         push_len(0);
         send_pkt(0, 0, 2);
      join
      rst_n = 1'b0;
      #2;
      checks++;
      if ({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, s_axis_tready, len_tready} !== {{(DSIZE+NB+3){1'b0}}, 1'b1}) begin
         errors++;
         $display("FAIL midrst_out got v=%0b d=%h k=%h l=%0b s_tready=%0b len_tready=%0b expected 0 0 0 0 0 1",
                  m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, s_axis_tready, len_tready);
      end
      @(posedge clock);
      #1 rst_n = 1'b1;
      clear_all();
      add_pkt(10, 3, 1);
      run_packets(0, 0);
      checks++;
      if (got_data.size() !== exp_data.size()) begin
         errors++; $display("FAIL midrst_beats got %0d expected %0d", got_data.size(), exp_data.size());
      end
      for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
         checks++;
         if ({got_data[i], got_keep[i], got_last[i]} !== {exp_data[i], exp_keep[i], exp_last[i]}) begin
            errors++;
            $display("FAIL midrst_beat%0d got d=%h k=%h l=%0b expected d=%h k=%h l=%0b", i,
                     got_data[i], got_keep[i], got_last[i], exp_data[i], exp_keep[i], exp_last[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      $display("test_reset done");
      test_passthrough();
      $display("test_passthrough done");
      test_cut("aligned", 12, 4, -1);
      $display("test_cut aligned L=4 done");
      test_cut("unaligned", 12, 6, -1);
      $display("test_cut unaligned L=6 done");
      test_cut("short_last", 11, 1, 10);
      $display("test_cut short_last L=1,10 done");
      test_drop();
      $display("test_drop done");
      test_queue_full_backpressure();
      $display("test_queue_full_backpressure done");
      test_random_back_to_back();
      $display("test_random_back_to_back done");
      test_reset_mid();
      $display("test_reset_mid done");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
